// File: rtl/sha256_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha256_pkg : shared widths, host FSM states and address helper     |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package sha256_pkg;

  localparam int BlockWidth  = 512;
  localparam int DigestWidth = 256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RESP     = 3'd2,
    ST_PROCESS  = 3'd3,
    ST_WAIT_DIG = 3'd4,
    ST_OUTPUT   = 3'd5
  } host_state_e;

  // Byte address of block word k; callers truncate to their bus width.
  function automatic logic [63:0] word_addr(input logic [63:0] base,
                                            input int unsigned k,
                                            input int unsigned bytes);
    return base + 64'(k) * 64'(bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_host_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha256_host_driver : splits a 512-bit block into bus writes, kicks |
// | the sha256 core and forwards its digest downstream.                |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module sha256_host_driver
  import sha256_pkg::*;
#(
  parameter bit                   SHA224     = 1'b0,
  parameter int                   DataWidth  = 64,
  parameter int                   AddrWidth  = 32,
  parameter int                   DataBytes  = DataWidth >> 3,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter int                   DigTimeout = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [BlockWidth-1:0]  blk_data_i,
  output logic [DigestWidth-1:0] digest_o,
  output logic                   digest_valid_o,
  input  logic                   digest_ready_i,
  output logic                   error_o,
  output logic [DataWidth-1:0]   m_reqdata_o,
  output logic [AddrWidth-1:0]   m_reqaddr_o,
  output logic                   m_reqvalid_o,
  output logic                   m_reqwrite_o,
  input  logic                   m_reqready_i,
  output logic [DataBytes-1:0]   m_reqstrobe_o,
  output logic                   m_rspready_o,
  input  logic                   m_rspvalid_i,
  input  logic [DataWidth-1:0]   m_rspdata_i,
  input  logic                   m_rsperror_i,
  output logic                   sha_process_o,
  output logic                   sha_digestack_o,
  input  logic [DigestWidth-1:0] sha_digest_i,
  input  logic                   sha_digestvalid_i
);

  localparam int NumWords = BlockWidth / DataWidth;
  localparam int KW       = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [KW-1:0] c_last = KW'(NumWords - 1);
  localparam logic [DigestWidth-1:0] c_dig_mask =
    SHA224 ? {32'h0, {224{1'b1}}} : {DigestWidth{1'b1}};

  host_state_e            r_state;
  host_state_e            w_state_nxt;
  logic [BlockWidth-1:0]  r_block;
  logic [KW-1:0]          r_k;
  logic [31:0]            r_tmo;
  logic [DigestWidth-1:0] r_digest;

  logic [8:0]             w_lsb;
  logic [DataWidth-1:0]   w_word;
  logic [63:0]            w_addr64;
  logic                   w_rsp_now;
  logic                   w_rsp_ok;
  logic                   w_rsp_err;
  logic                   w_last;
  logic                   w_tmo_hit;
  logic                   w_unused;

  // Word 0 sits in the top bits of the block, so the select walks downward.
  assign w_lsb    = 9'(BlockWidth - DataWidth) - 9'(r_k) * 9'(DataWidth);
  assign w_word   = r_block[w_lsb +: DataWidth];
  assign w_addr64 = word_addr(64'(BaseAddr), 32'(r_k), 32'(DataBytes));

  // A response arriving together with the request accept completes the word.
  assign w_rsp_now = ((r_state == ST_WRITE) && m_reqready_i && m_rspvalid_i) ||
                     ((r_state == ST_RESP) && m_rspvalid_i);
  assign w_rsp_err = w_rsp_now && m_rsperror_i;
  assign w_rsp_ok  = w_rsp_now && !m_rsperror_i;
  assign w_last    = (r_k == c_last);
  assign w_tmo_hit = (DigTimeout != 0) && (r_tmo == 32'(DigTimeout - 1));

  assign digest_o  = r_digest;
  assign w_unused  = ^{m_rspdata_i, w_addr64};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_block  <= '0;
      r_k      <= '0;
      r_tmo    <= '0;
      r_digest <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (blk_valid_i) begin
            r_block <= blk_data_i;
            r_k     <= '0;
          end
        end
        ST_WRITE, ST_RESP: begin
          if (w_rsp_ok && !w_last) r_k <= r_k + KW'(1);
        end
        ST_PROCESS: r_tmo <= '0;
        ST_WAIT_DIG: begin
          r_tmo <= r_tmo + 32'd1;
          if (sha_digestvalid_i) r_digest <= sha_digest_i & c_dig_mask;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    blk_ready_o     = 1'b0;
    digest_valid_o  = 1'b0;
    error_o         = 1'b0;
    m_reqdata_o     = '0;
    m_reqaddr_o     = '0;
    m_reqvalid_o    = 1'b0;
    m_reqwrite_o    = 1'b0;
    m_reqstrobe_o   = '0;
    m_rspready_o    = 1'b0;
    sha_process_o   = 1'b0;
    sha_digestack_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        blk_ready_o = !rst_i;
        if (blk_valid_i) w_state_nxt = ST_WRITE;
      end
      ST_WRITE, ST_RESP: begin
        m_rspready_o = 1'b1;
        error_o      = w_rsp_err;
        if (r_state == ST_WRITE) begin
          m_reqvalid_o  = 1'b1;
          m_reqwrite_o  = 1'b1;
          m_reqstrobe_o = '1;
          m_reqdata_o   = w_word;
          m_reqaddr_o   = w_addr64[AddrWidth-1:0];
        end
        if (w_rsp_err)                                w_state_nxt = ST_IDLE;
        else if (w_rsp_ok)                            w_state_nxt = w_last ? ST_PROCESS : ST_WRITE;
        else if (r_state == ST_WRITE && m_reqready_i) w_state_nxt = ST_RESP;
      end
      ST_PROCESS: begin
        sha_process_o = 1'b1;
        w_state_nxt   = ST_WAIT_DIG;
      end
      ST_WAIT_DIG: begin
        // A digest arriving on the timeout cycle still wins.
        if (sha_digestvalid_i) begin
          w_state_nxt = ST_OUTPUT;
        end else if (w_tmo_hit) begin
          error_o     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OUTPUT: begin
        digest_valid_o  = 1'b1;
        sha_digestack_o = digest_ready_i;
        if (digest_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
